frame_state_latch: RTL and testbench



---
 rtl/chess_vga_pkg.sv | 11 +
 rtl/vsync_edge_detect.sv | 29 ++
 rtl/frame_state_latch.sv | 92 +++++++++
 tb/tb_frame_state_latch.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/chess_vga_pkg.sv
// Shared types and constants for the chess VGA display path.
package chess_vga_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } latch_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/vsync_edge_detect.sv
// Detects the vsync leading edge (polarity-configurable) and emits a registered frame tick.
module vsync_edge_detect #(
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic clk_vga,
    input  logic rst,
    input  logic vga_vs,
    output logic vs_edge,
    output logic frame_tick
);

    logic vs_act;
    logic vs_prev;

    assign vs_act  = VS_ACTIVE_LOW ? ~vga_vs : vga_vs;
    assign vs_edge = vs_act && !vs_prev;

    // vs_prev resets to active so a sync already asserted at reset release is not an edge.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            vs_prev    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_prev    <= vs_act;
            frame_tick <= vs_edge;
        end
    end

endmodule

// File: rtl/frame_state_latch.sv
// Filters the synchronized state for stability and commits it only at the vsync leading edge.
module frame_state_latch
    import chess_vga_pkg::*;
#(
    parameter int             bits          = 1,
    parameter int             STABLE_CYCLES = 4,
    parameter logic [bits-1:0] RESET_STATE  = '0,
    parameter bit             VS_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk_vga,
    input  logic                   rst,
    input  logic [bits-1:0]        state_vga,
    input  logic                   vga_vs,
    output logic [bits-1:0]        state_frame,
    output logic                   state_update,
    output logic                   frame_tick,
    output logic                   pending,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    logic [bits-1:0] cand;
    logic [CW-1:0]   cnt;
    logic            qualified;
    logic            vs_edge;
    logic            commit;
    logic [bits-1:0] pend_val, pend_val_n;
    logic [bits-1:0] next_frame;
    latch_state_t    state, state_n;

    vsync_edge_detect #(
        .VS_ACTIVE_LOW(VS_ACTIVE_LOW)
    ) u_vs (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .vga_vs     (vga_vs),
        .vs_edge    (vs_edge),
        .frame_tick (frame_tick)
    );

    // Any change restarts the run; bits skewed by a cycle show up as a short-lived code.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            cand <= RESET_STATE;
            cnt  <= '0;
        end else if (state_vga != cand) begin
            cand <= state_vga;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign qualified = (cnt == CNT_MAX);
    assign pending   = (state == S_PENDING);

    always_comb begin
        commit     = vs_edge && (state == S_PENDING);
        next_frame = commit ? pend_val : state_frame;
        state_n    = state;
        pend_val_n = pend_val;
        // Compare against the value visible after this cycle's commit, not the current one.
        if (qualified && cand != next_frame) begin
            pend_val_n = cand;
            state_n    = S_PENDING;
        end else if (qualified) begin
            state_n = S_IDLE;
        end else if (commit) begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state        <= S_IDLE;
            pend_val     <= RESET_STATE;
            state_frame  <= RESET_STATE;
            state_update <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_n;
            pend_val     <= pend_val_n;
            state_frame  <= next_frame;
            state_update <= commit;
            if (vs_edge)
                frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_state_latch.sv
// Directed bench for frame_state_latch with a queue-based scoreboard on tick/update pulses.
module tb_frame_state_latch;
    import chess_vga_pkg::*;

    logic                   clk_vga = 1'b0;
    logic                   rst;
    logic [3:0]             state_vga;
    logic                   vga_vs;
    logic [3:0]             state_frame;
    logic                   state_update;
    logic                   frame_tick;
    logic                   pending;
    logic [FRAME_CNT_W-1:0] frame_count;

    int total = 0;
    int bad   = 0;
    int tick_q[$];
    logic [3:0] upd_q[$];
    int fc_model = 0;

    frame_state_latch #(
        .bits(4), .STABLE_CYCLES(4), .RESET_STATE(4'h0), .VS_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_vga      (clk_vga),
        .rst          (rst),
        .state_vga    (state_vga),
        .vga_vs       (vga_vs),
        .state_frame  (state_frame),
        .state_update (state_update),
        .frame_tick   (frame_tick),
        .pending      (pending),
        .frame_count  (frame_count)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs settle at posedge; sample them on the opposite edge.
    always @(negedge clk_vga) begin
        if (frame_tick) begin
            if (tick_q.size() == 0) chk("unexpected_frame_tick", 1, 0);
            else chk("tick_frame_count", int'(frame_count), tick_q.pop_front());
        end
        if (state_update) begin
            if (upd_q.size() == 0) chk("unexpected_state_update", 1, 0);
            else chk("update_state_frame", int'(state_frame), int'(upd_q.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_vga);
            #1;
        end
    endtask

    // One-cycle active-low vsync pulse; caller passes the commit it expects.
    task automatic frame_edge(input bit exp_upd, input logic [3:0] val);
        fc_model = (fc_model + 1) & 16'hFFFF;
        tick_q.push_back(fc_model);
        if (exp_upd) upd_q.push_back(val);
        vga_vs = 1'b0;
        cyc(1);
        vga_vs = 1'b1;
        cyc(2);
    endtask

    initial begin
        rst = 1'b1;
        state_vga = 4'h0;
        vga_vs = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(4);
        chk("reset_state_frame", int'(state_frame), 0);
        chk("reset_frame_count", int'(frame_count), 0);
        chk("reset_pending", int'(pending), 0);
        vga_vs = 1'b1;
        cyc(2);
        chk("no_tick_count_still_0", int'(frame_count), 0);
        frame_edge(1'b0, 4'h0);
        chk("first_tick_count", int'(frame_count), 1);

        // Qualify 9, then revert to the frame value: the change is dropped.
        state_vga = 4'h9;
        cyc(8);
        chk("pending_9", int'(pending), 1);
        state_vga = 4'h0;
        cyc(7);
        chk("revert_clears_pending", int'(pending), 0);
        frame_edge(1'b0, 4'h0);
        chk("revert_state_frame", int'(state_frame), 0);

        // Toggling every 2 cycles never qualifies; two edges land inside.
        for (int i = 0; i < 50; i++) begin
            state_vga = i[0] ? 4'h7 : 4'h3;
            if (i == 10 || i == 35) begin
                fc_model = (fc_model + 1) & 16'hFFFF;
                tick_q.push_back(fc_model);
                vga_vs = 1'b0;
            end else begin
                vga_vs = 1'b1;
            end
            cyc(2);
        end
        chk("toggle_pending", int'(pending), 0);
        state_vga = 4'h0;
        cyc(8);
        chk("toggle_state_frame", int'(state_frame), 0);
        chk("toggle_no_pending_after", int'(pending), 0);

        // 0 -> 5: pending exactly STABLE_CYCLES+1 cycles after first sample.
        state_vga = 4'h5;
        cyc(5);
        chk("pending_not_yet", int'(pending), 0);
        cyc(1);
        chk("pending_5_asserted", int'(pending), 1);
        chk("frame_held_0", int'(state_frame), 0);
        cyc(14);
        frame_edge(1'b1, 4'h5);
        chk("commit_5", int'(state_frame), 5);
        chk("pending_clear_after_commit", int'(pending), 0);

        // Edge coincides with 6 qualifying while 9 is pending.
        state_vga = 4'h9;
        cyc(8);
        chk("pending_9_again", int'(pending), 1);
        state_vga = 4'h6;
        cyc(5);
        frame_edge(1'b1, 4'h9);
        chk("coincide_frame_9", int'(state_frame), 9);
        chk("coincide_pending_6", int'(pending), 1);
        cyc(3);
        frame_edge(1'b1, 4'h6);
        chk("second_commit_6", int'(state_frame), 6);
        chk("pending_clear_6", int'(pending), 0);

        // Counter wrap.
        force dut.frame_count = 16'hFFFF;
        cyc(1);
        release dut.frame_count;
        cyc(1);
        chk("preload_ffff", int'(frame_count), 16'hFFFF);
        fc_model = 16'hFFFF;
        frame_edge(1'b0, 4'h0);
        chk("wrap_to_0", int'(frame_count), 0);

        // Reset in the middle of a pending change.
        state_vga = 4'h3;
        cyc(8);
        chk("pending_3", int'(pending), 1);
        rst = 1'b1;
        state_vga = 4'h0;
        cyc(1);
        chk("rst_pending", int'(pending), 0);
        chk("rst_state_frame", int'(state_frame), 0);
        chk("rst_state_update", int'(state_update), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        rst = 1'b0;
        fc_model = 0;
        cyc(8);
        chk("post_rst_pending", int'(pending), 0);

        chk("tick_queue_drained", tick_q.size(), 0);
        chk("update_queue_drained", upd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
